// File: rtl/ext_bus_target_if.sv
// External MCU bus as seen from the target: address/data from the initiator,
// active-low strobes, status input, and the target's response signals.
interface ext_bus_target_if;
    logic [15:0] ADDR;
    logic [15:0] DIN;
    logic        RDN;
    logic        WR0N;
    logic        WR1N;
    logic [15:0] STATUS_IN;
    logic [15:0] DOUT;
    logic        DOE;
    logic [15:0] REG0_OUT;
    logic        WR_PULSE;
    logic        ERR;

    // Target side: samples the bus and drives read data and status pulses
    modport slave (
        input  ADDR, DIN, RDN, WR0N, WR1N, STATUS_IN,
        output DOUT, DOE, REG0_OUT, WR_PULSE, ERR
    );

    // Initiator side: drives address, data and strobes
    modport master (
        output ADDR, DIN, RDN, WR0N, WR1N, STATUS_IN,
        input  DOUT, DOE, REG0_OUT, WR_PULSE, ERR
    );
endinterface

// File: rtl/ext_bus_target.sv
// Synchronous responder on the MCU external bus. Strobes are synchronized
// into CLK, an FSM tracks each access, reads drive the data bus from a small
// register file (top offset returns STATUS_IN), and writes commit byte lanes
// once every write strobe has been released.
module ext_bus_target #(
    parameter logic [15:0] BASE_ADDR = 16'hF000,
    parameter int          AW        = 3
) (
    input logic             CLK,
    input logic             RESETN,
    ext_bus_target_if.slave bus
);
    localparam int            NREG    = 2 ** AW;
    localparam logic [AW-1:0] TOP_OFF = {AW{1'b1}};

    typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_t;

    state_t                  r_state, w_state_next;
    logic [2:0]              r_strb_meta, r_strb_sync;   // {WR1N, WR0N, RDN}, raw polarity
    logic                    w_s_rd, w_s_w0, w_s_w1, w_s_wr;
    logic [15:0]             r_addr, w_addr_next;
    logic [15:0]             r_data, w_data_next;
    logic [1:0]              r_mask, w_mask_next;
    logic                    r_doe, w_doe_next;
    logic [15:0]             r_dout, w_dout_next;
    logic                    r_wr_pulse, r_err, w_err_next;
    logic                    w_commit, w_reg_we;
    logic [15:0]             w_acc_addr;
    logic [AW-1:0]           w_acc_off;
    logic                    w_acc_in_win, w_in_win;
    logic [NREG-1:0][15:0]   w_regs;

    // Two-flop synchronizers; idle level is high so reset looks like "no strobe"
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_strb_meta <= 3'b111;
            r_strb_sync <= 3'b111;
        end else begin
            r_strb_meta <= {bus.WR1N, bus.WR0N, bus.RDN};
            r_strb_sync <= r_strb_meta;
        end
    end

    assign w_s_rd = ~r_strb_sync[0];
    assign w_s_w0 = ~r_strb_sync[1];
    assign w_s_w1 = ~r_strb_sync[2];
    assign w_s_wr = w_s_w0 | w_s_w1;

    // In IDLE the access address is the live bus; afterwards the latched copy
    assign w_acc_addr   = (r_state == IDLE) ? bus.ADDR : r_addr;
    assign w_acc_off    = w_acc_addr[AW-1:0];
    assign w_acc_in_win = (w_acc_addr[15:AW] == BASE_ADDR[15:AW]);
    assign w_in_win     = (r_addr[15:AW] == BASE_ADDR[15:AW]);

    // Next-state, access latches, error and commit decisions
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        w_mask_next  = r_mask;
        w_err_next   = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s_rd && w_s_wr) begin
                    w_state_next = DRAIN;
                    w_err_next   = 1'b1;
                end else if (w_s_rd) begin
                    w_state_next = READ;
                    w_addr_next  = bus.ADDR;
                end else if (w_s_wr) begin
                    w_state_next = WRITE;
                    w_addr_next  = bus.ADDR;
                    w_mask_next  = 2'b00;
                end
            end
            READ: begin
                if (w_s_wr) begin
                    w_state_next = DRAIN;
                    w_err_next   = 1'b1;
                end else if (!w_s_rd) begin
                    w_state_next = IDLE;
                end
            end
            WRITE: begin
                // Commit uses r_data/r_mask: the values from the last strobed cycle
                w_data_next = bus.DIN;
                w_mask_next = r_mask | {w_s_w1, w_s_w0};
                if (w_s_rd) begin
                    w_state_next = DRAIN;
                    w_err_next   = 1'b1;
                end else if (!w_s_wr) begin
                    w_state_next = IDLE;
                    w_commit     = w_in_win;
                end
            end
            DRAIN: begin
                if (!w_s_rd && !w_s_wr) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Read data path: enabled only while heading into/staying in READ inside the window
    always_comb begin
        w_doe_next  = (w_state_next == READ) && w_acc_in_win;
        w_dout_next = 16'h0000;
        if (w_doe_next) begin
            w_dout_next = (w_acc_off == TOP_OFF) ? bus.STATUS_IN : w_regs[w_acc_off];
        end
    end

    // Top offset is read-only: the write still pulses but nothing is stored
    assign w_reg_we = w_commit && (r_addr[AW-1:0] != TOP_OFF);

    // FSM state, access latches and registered outputs
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state    <= IDLE;
            r_addr     <= 16'h0000;
            r_data     <= 16'h0000;
            r_mask     <= 2'b00;
            r_doe      <= 1'b0;
            r_dout     <= 16'h0000;
            r_wr_pulse <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_data     <= w_data_next;
            r_mask     <= w_mask_next;
            r_doe      <= w_doe_next;
            r_dout     <= w_dout_next;
            r_wr_pulse <= w_commit;
            r_err      <= w_err_next;
        end
    end

    // One 16-bit register per offset with independent byte-lane enables
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        localparam logic [AW-1:0] OFF = gi;
        logic [15:0] r_word;

        // Byte-lane commit into this register
        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                r_word <= 16'h0000;
            end else if (w_reg_we && (r_addr[AW-1:0] == OFF)) begin
                if (r_mask[0]) r_word[7:0]  <= r_data[7:0];
                if (r_mask[1]) r_word[15:8] <= r_data[15:8];
            end
        end

        assign w_regs[gi] = r_word;
    end

    assign bus.DOUT     = r_dout;
    assign bus.DOE      = r_doe;
    assign bus.REG0_OUT = w_regs[0];
    assign bus.WR_PULSE = r_wr_pulse;
    assign bus.ERR      = r_err;
endmodule
